// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 32-bit ALU between two requesters.
// Define ALU_ARB_FLAGS_EN to capture the ALU flag inputs into rspN_flags; otherwise they read 4'b0000.
module alu_arbiter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [1:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [1:0]  req1_op,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic [3:0]  rsp0_flags,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic [3:0]  rsp1_flags,
   output logic [31:0] alu_bussa,
   output logic [31:0] alu_bussb,
   output logic [1:0]  alu_control,
   input  logic [31:0] alu_output,
   input  logic        alu_carryout,
   input  logic        alu_zero,
   input  logic        alu_overflow,
   input  logic        alu_negative,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   state_t     state;
   logic       owner;
   logic       last_grant;
   logic [3:0] count;
   logic       grant0;
   logic       grant1;
   logic       capture;
   logic       rsp_done;

   // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         grant0 = last_grant;
         grant1 = ~last_grant;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
   end

   assign req0_ready = (state == IDLE) && grant0;
   assign req1_ready = (state == IDLE) && grant1;
   assign busy       = (state != IDLE);
   assign capture    = (state == EXEC) && (count == 4'd1);
   assign rsp_done   = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= 1'b1;
         last_grant  <= 1'b1;
         count       <= 4'd0;
         alu_bussa   <= 32'd0;
         alu_bussb   <= 32'd0;
         alu_control <= 2'b00;
         rsp0_valid  <= 1'b0;
         rsp1_valid  <= 1'b0;
         rsp0_result <= 32'd0;
         rsp1_result <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req0_ready || req1_ready) begin
                  alu_bussa   <= req1_ready ? req1_a  : req0_a;
                  alu_bussb   <= req1_ready ? req1_b  : req0_b;
                  alu_control <= req1_ready ? req1_op : req0_op;
                  owner       <= req1_ready;
                  count       <= WAIT_LOAD;
                  state       <= EXEC;
               end
            end
            EXEC: begin
               count <= count - 4'd1;
               if (capture) begin
                  if (owner) begin
                     rsp1_result <= alu_output;
                     rsp1_valid  <= 1'b1;
                  end else begin
                     rsp0_result <= alu_output;
                     rsp0_valid  <= 1'b1;
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               if (rsp_done) begin
                  if (owner) rsp1_valid <= 1'b0;
                  else       rsp0_valid <= 1'b0;
                  last_grant <= owner;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_FLAGS_EN
   logic [3:0] flags0_q;
   logic [3:0] flags1_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags0_q <= 4'd0;
         flags1_q <= 4'd0;
      end else if (capture) begin
         if (owner) flags1_q <= {alu_negative, alu_overflow, alu_zero, alu_carryout};
         else       flags0_q <= {alu_negative, alu_overflow, alu_zero, alu_carryout};
      end
   end

   assign rsp0_flags = flags0_q;
   assign rsp1_flags = flags1_q;
`else
   logic unused_flags;

   assign unused_flags = ^{alu_negative, alu_overflow, alu_zero, alu_carryout};
   assign rsp0_flags   = 4'b0000;
   assign rsp1_flags   = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural stand-in for the shared ALU_MIPS.
// Flag expectations follow ALU_ARB_FLAGS_EN: hand-computed values when defined, 4'b0000 otherwise.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0]  req0_op, req1_op;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [31:0] rsp0_result, rsp1_result;
   logic [3:0]  rsp0_flags, rsp1_flags;
   logic [31:0] alu_bussa, alu_bussb;
   logic [1:0]  alu_control;
   logic [31:0] alu_output;
   logic        alu_carryout, alu_zero, alu_overflow, alu_negative;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WAIT_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
      .alu_bussa(alu_bussa), .alu_bussb(alu_bussb), .alu_control(alu_control),
      .alu_output(alu_output), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow), .alu_negative(alu_negative), .busy(busy)
   );

   // Stand-in ALU: 00 add, 01 xor, 10 sub, 11 slt; flags {negative, overflow, zero, carryout}.
   always_comb begin
      logic [32:0] sum;
      logic        ovf;
      sum          = 33'd0;
      ovf          = 1'b0;
      alu_output   = 32'd0;
      alu_carryout = 1'b0;
      alu_overflow = 1'b0;
      case (alu_control)
         2'b00: begin
            sum          = {1'b0, alu_bussa} + {1'b0, alu_bussb};
            alu_output   = sum[31:0];
            alu_carryout = sum[32];
            alu_overflow = (alu_bussa[31] == alu_bussb[31]) && (sum[31] != alu_bussa[31]);
         end
         2'b01: alu_output = alu_bussa ^ alu_bussb;
         2'b10: begin
            sum          = {1'b0, alu_bussa} + {1'b0, ~alu_bussb} + 33'd1;
            alu_output   = sum[31:0];
            alu_carryout = sum[32];
            alu_overflow = (alu_bussa[31] != alu_bussb[31]) && (sum[31] != alu_bussa[31]);
         end
         default: begin
            sum        = {1'b0, alu_bussa} + {1'b0, ~alu_bussb} + 33'd1;
            ovf        = (alu_bussa[31] != alu_bussb[31]) && (sum[31] != alu_bussa[31]);
            alu_output = {31'd0, sum[31] ^ ovf};
         end
      endcase
      alu_zero     = (alu_output == 32'd0);
      alu_negative = alu_output[31];
   end

   function automatic logic [3:0] exp_flags(input logic [3:0] f);
`ifdef ALU_ARB_FLAGS_EN
      return f;
`else
      return (f & 4'b0000);
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      check("rst_bussa", alu_bussa, 32'd0);
      check("rst_control", 32'(alu_control), 32'd0);
      check("rst_result0", rsp0_result, 32'd0);
      #10 reset = 1'b0;
      tick();

      // Single add from req0
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 2'b00;
      #1;
      check("add_req0_ready", 32'(req0_ready), 32'd1);
      check("add_req1_ready", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      check("add_busy", 32'(busy), 32'd1);
      check("add_bussa", alu_bussa, 32'd5);
      check("add_bussb", alu_bussb, 32'd7);
      check("add_rsp_early", 32'(rsp0_valid), 32'd0);
      tick();
      check("add_rsp_early2", 32'(rsp0_valid), 32'd0);
      tick();
      check("add_rsp_valid", 32'(rsp0_valid), 32'd1);
      check("add_result", rsp0_result, 32'd12);
      check("add_flags", 32'(rsp0_flags), 32'(exp_flags(4'b0000)));
      check("add_rsp1_quiet", 32'(rsp1_valid), 32'd0);
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      check("add_done_valid", 32'(rsp0_valid), 32'd0);
      check("add_done_idle", 32'(busy), 32'd0);

      // Fresh reset so tie-breaking restarts at req0; both requesters always valid
      reset = 1'b1; #2; reset = 1'b0;
      tick();
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 2'b00;
      req1_valid = 1'b1; req1_a = 32'hF0F0_0000; req1_b = 32'h0FF0_0000; req1_op = 2'b01;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      for (int g = 0; g < 4; g++) begin
         #1;
         check("rr_ready0", 32'(req0_ready), (g % 2 == 0) ? 32'd1 : 32'd0);
         check("rr_ready1", 32'(req1_ready), (g % 2 == 1) ? 32'd1 : 32'd0);
         tick();
         check("rr_bussa", alu_bussa, (g % 2 == 0) ? 32'd1 : 32'hF0F0_0000);
         tick();
         tick();
         if (g % 2 == 0) begin
            check("rr_rsp0_valid", 32'(rsp0_valid), 32'd1);
            check("rr_rsp1_quiet", 32'(rsp1_valid), 32'd0);
            check("rr_add_result", rsp0_result, 32'd3);
         end else begin
            check("rr_rsp1_valid", 32'(rsp1_valid), 32'd1);
            check("rr_rsp0_quiet", 32'(rsp0_valid), 32'd0);
            check("rr_xor_result", rsp1_result, 32'hFF00_0000);
            check("rr_xor_flags", 32'(rsp1_flags), 32'(exp_flags(4'b1000)));
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      check("rr_rsp1_kept", rsp1_result, 32'hFF00_0000);

      // sub 3-3, then stall the response while req1 waits
      req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd3; req0_op = 2'b10;
      #1;
      check("sub_ready", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_op = 2'b00;
      tick();
      tick();
      check("sub_result", rsp0_result, 32'd0);
      check("sub_flags", 32'(rsp0_flags), 32'(exp_flags(4'b0011)));
      for (int s = 0; s < 5; s++) begin
         check("stall_valid", 32'(rsp0_valid), 32'd1);
         check("stall_result", rsp0_result, 32'd0);
         check("stall_control", 32'(alu_control), 32'd2);
         check("stall_req1_ready", 32'(req1_ready), 32'd0);
         tick();
      end
      rsp0_ready = 1'b1;
      #1;
      check("stall_req1_resp", 32'(req1_ready), 32'd0);
      tick();
      rsp0_ready = 1'b0;
      check("stall_released", 32'(rsp0_valid), 32'd0);
      check("stall_req1_now", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      check("req1_bussa", alu_bussa, 32'd10);

      // Reset in the middle of EXEC discards the transaction
      tick();
      reset = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_bussa", alu_bussa, 32'd0);
      check("mid_rst_rsp1", 32'(rsp1_valid), 32'd0);
      check("mid_rst_res1", rsp1_result, 32'd0);
      #2 reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("post_rst_no_rsp", 32'(rsp1_valid | rsp0_valid), 32'd0);
      end

      // slt -1 < 1 with both valid: req0 wins the first tie
      req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_op = 2'b11;
      req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4; req1_op = 2'b00;
      #1;
      check("slt_tie_ready0", 32'(req0_ready), 32'd1);
      check("slt_tie_ready1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      tick();
      check("slt_valid", 32'(rsp0_valid), 32'd1);
      check("slt_result", rsp0_result, 32'd1);
      check("slt_flags", 32'(rsp0_flags), 32'(exp_flags(4'b0000)));
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;

      // sub 0-1 immediately after the previous handshake
      req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd1; req0_op = 2'b10;
      #1;
      check("neg_ready", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      check("neg_result", rsp0_result, 32'hFFFF_FFFF);
      check("neg_flags", 32'(rsp0_flags), 32'(exp_flags(4'b1000)));
      rsp0_ready = 1'b1;
      tick();
      rsp0_ready = 1'b0;
      check("neg_done", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
